// File: rtl/jacobi_result_sender_pkg.sv
// Shared constants and types for the Jacobi result output path.
package jacobi_result_sender_pkg;

   localparam int unsigned JACOBI_N                  = 8;
   localparam int unsigned JACOBI_LOG2_N             = 3;
   localparam int unsigned JACOBI_V_OFFSET           = 64;
   localparam int unsigned JACOBI_ADDR_WIDTH         = 7;
   localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH  = 32;
   localparam int unsigned JACOBI_N_OUTPUT_DATA      = JACOBI_N + JACOBI_N * JACOBI_N;

   typedef enum logic [1:0] {
      IDLE,
      SEND_DIAG,
      SEND_V,
      DRAIN
   } sender_fsm_t;

endpackage

// File: rtl/jacobi_out_fifo.sv
// Two-entry synchronous FIFO of {last, data} between the RAM read port and the output handshake.
module jacobi_out_fifo #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         push_last,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         head_last,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty
);

   logic [W:0] mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {push_last, push_data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_data = mem[rd_ptr][W-1:0];
   assign head_last = mem[rd_ptr][W];
   assign full      = (cnt == 2'd2);
   assign empty     = (cnt == 2'd0);

endmodule

// File: rtl/jacobi_result_sender.sv
// Streams the eigenvalue diagonal and then the eigenvector matrix V from the shared RAM to the
// microcontroller, with read issue throttled by buffer credits.
module jacobi_result_sender
   import jacobi_result_sender_pkg::*;
#(
   parameter int unsigned N          = JACOBI_N,
   parameter int unsigned WORD_WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
   parameter int unsigned ADDR_WIDTH = JACOBI_ADDR_WIDTH,
   parameter int unsigned V_OFFSET   = JACOBI_V_OFFSET
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         ram_en_o,
   output logic [ADDR_WIDTH-1:0]        ram_addr_o,
   input  logic [WORD_WIDTH-1:0]        ram_dout_i,
   output logic signed [WORD_WIDTH-1:0] out_dat_o,
   output logic                         out_vld_o,
   input  logic                         out_rdy_i,
   output logic                         out_last_o
);

   localparam int unsigned LOG2N = $clog2(N);

   sender_fsm_t           state;
   logic [LOG2N-1:0]      row;
   logic [LOG2N-1:0]      col;
   logic [LOG2N-1:0]      col_nxt;
   logic [LOG2N-1:0]      row_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] diag_nxt;
   logic [ADDR_WIDTH-1:0] v_nxt;
   logic                  rd_vld_q;
   logic                  rd_last_q;
   logic                  rd_issue;
   logic                  rd_final;
   logic                  pop;
   logic [2:0]            used;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  head_last;
   logic [WORD_WIDTH-1:0] head_data;

   assign pop = out_vld_o & out_rdy_i;

   // Credits: buffered words plus the read in flight, less this cycle's pop, must stay below two.
   always_comb begin
      used     = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
      used     = used + 3'(rd_vld_q);
      rd_issue = ((state == SEND_DIAG) || (state == SEND_V)) && (used < (3'd2 + 3'(pop)));
      rd_final = rd_issue && (state == SEND_V) && (row == '1) && (col == '1);
      col_nxt  = col + 1'b1;
      row_nxt  = (col == '1) ? row + 1'b1 : row;
      diag_nxt = (ADDR_WIDTH'(col_nxt) << LOG2N) + ADDR_WIDTH'(col_nxt);
      v_nxt    = ADDR_WIDTH'(V_OFFSET) + (ADDR_WIDTH'(row_nxt) << LOG2N) + ADDR_WIDTH'(col_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         addr_q    <= '0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         rd_vld_q  <= rd_issue;
         rd_last_q <= rd_final;
         done_o    <= 1'b0;
         case (state)
            IDLE: begin
               // A start coinciding with the done pulse belongs to the finished transfer.
               if (start_i && !done_o) begin
                  state  <= SEND_DIAG;
                  busy_o <= 1'b1;
                  row    <= '0;
                  col    <= '0;
                  addr_q <= '0;
               end
            end
            SEND_DIAG: begin
               if (rd_issue) begin
                  if (col == '1) begin
                     state  <= SEND_V;
                     col    <= '0;
                     row    <= '0;
                     addr_q <= ADDR_WIDTH'(V_OFFSET);
                  end else begin
                     col    <= col_nxt;
                     addr_q <= diag_nxt;
                  end
               end
            end
            SEND_V: begin
               if (rd_issue) begin
                  if (rd_final) begin
                     state  <= DRAIN;
                     row    <= '0;
                     col    <= '0;
                     addr_q <= '0;
                  end else begin
                     col    <= col_nxt;
                     row    <= row_nxt;
                     addr_q <= v_nxt;
                  end
               end
            end
            DRAIN: begin
               if (pop && head_last) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   jacobi_out_fifo #(
      .W (WORD_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_vld_q),
      .push_last (rd_last_q),
      .push_data (ram_dout_i),
      .pop       (pop),
      .head_last (head_last),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign ram_en_o   = rd_issue;
   assign ram_addr_o = addr_q;
   assign out_vld_o  = ~fifo_empty;
   assign out_dat_o  = head_data;
   assign out_last_o = head_last;

endmodule

// File: doc/jacobi_result_sender.md
Name: jacobi_result_sender

Overview:
Output-side counterpart of the Jacobi input path. After the main controller finishes its sweeps, it issues a one-cycle start pulse. This block then reads results from the shared dual-port RAM: first the N diagonal eigenvalues of A, then the N×N eigenvector matrix V in row-major order. It streams them to the microcontroller over a valid/ready interface, absorbing the RAM read latency and output backpressure with a small credit-controlled buffer.

Parameters:
N, 8, matrix dimension (power of two)
WORD_WIDTH, 32, data word width (JACOBI_OUTPUT_WORD_WIDTH)
ADDR_WIDTH, 7, RAM address width (JACOBI_ADDR_WIDTH)
V_OFFSET, 64, RAM base address of V (JACOBI_V_OFFSET)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request to begin transmission
busy_o  out  1  high from the cycle after start is accepted until the last word is accepted
done_o  out  1  one-cycle pulse on acceptance of the last word
ram_en_o  out  1  RAM read enable (port dedicated to this block)
ram_addr_o  out  ADDR_WIDTH  RAM read address
ram_dout_i  in  WORD_WIDTH  RAM read data, valid exactly 1 cycle after ram_en_o
out_dat_o  out  WORD_WIDTH  signed output word
out_vld_o  out  1  output valid
out_rdy_i  in  1  microcontroller ready
out_last_o  out  1  high with the final (N+N*N-th) word

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, buffer empty. busy_o=0, done_o=0, ram_en_o=0, ram_addr_o=0, out_vld_o=0, out_last_o=0, out_dat_o=0.
- FSM states:
  - IDLE -> SEND_DIAG on start_i.
  - SEND_DIAG -> SEND_V after read N-1 is issued.
  - SEND_V -> DRAIN after read N*N-1 is issued.
  - DRAIN -> IDLE when the last word is accepted (out_vld_o & out_rdy_i & out_last_o).
- start_i is ignored in any state other than IDLE.
- Addresses:
  - SEND_DIAG, index i: (i<<log2 N)+i.
  - SEND_V, row r and column c: V_OFFSET+(r<<log2 N)+c, with c incrementing and wrapping to 0 while r increments.
- Read issue rule: ram_en_o is high in a cycle only if (buffer occupancy + reads in flight − pop this cycle) < 2. No read is issued in IDLE or DRAIN.
- Buffer: 2-entry FIFO. Write is ram_dout_i, one cycle after ram_en_o. Pop occurs when out_vld_o & out_rdy_i.
  - out_vld_o = not empty.
  - out_dat_o and out_last_o come from the head entry.
  - A simultaneous push and pop on a full buffer is legal. Overflow is impossible by the credit rule.
- Latency: start_i in cycle 0 -> ram_en_o with address 0 in cycle 1 -> data in the buffer at the end of cycle 2 -> out_vld_o in cycle 3.
- Throughput: with out_rdy_i held high, one word per cycle and no bubbles. Total N+N*N words (72 at default).
- Handshake: while out_vld_o=1 and out_rdy_i=0, out_dat_o and out_last_o stay stable. out_vld_o never drops without acceptance.
- out_last_o is tagged on the entry whose read was the final V read.
- done_o is registered and goes high the cycle after the last acceptance. busy_o falls in the same cycle.
- A start_i arriving in the same cycle as done_o is ignored; start must be re-issued once IDLE.
- Data is passed through unmodified; no arithmetic on data. Address arithmetic is unsigned, ADDR_WIDTH wide, and never wraps for legal parameters.
- Reset mid-transfer aborts immediately. The buffer is flushed, no done_o pulse is produced, and a subsequent start restarts from diagonal index 0.

Decomposition:
- Package common holds:
  - JACOBI_N, JACOBI_LOG2_N, JACOBI_V_OFFSET, JACOBI_ADDR_WIDTH, JACOBI_OUTPUT_WORD_WIDTH
  - new constant JACOBI_N_OUTPUT_DATA = N+N*N
  - enum sender_fsm_t {IDLE, SEND_DIAG, SEND_V, DRAIN}
- One sub-module: jacobi_out_fifo, a 2-entry synchronous FIFO of {last, data} with push/pop/full/empty, async active-low reset.

Test Plan:
- Full-speed stream: preload RAM with word=address, hold out_rdy_i=1, pulse start.
  - Output order is 0,9,18,…,63 then 64,65,…,127.
  - The 72 words are accepted in 72 consecutive cycles, the first in cycle 3.
  - out_last_o=1 only on 127, and done_o pulses once.
- Backpressure: toggle out_rdy_i at random (about 30% ready) for the same transfer.
  - No word is lost or duplicated and data is stable while stalled.
  - ram_en_o is never issued when occupancy+in-flight≥2.
- Long stall: hold out_rdy_i=0 for 20 cycles after the first out_vld_o.
  - The buffer holds exactly 2 words, ram_en_o stays low, and the stream resumes correctly.
- Start while busy: pulse start_i at word 10 and again in the done_o cycle.
  - Both pulses are ignored and exactly 72 words are sent.
- Reset mid-transfer: assert rst_n=0 asynchronously at word 40 (between clock edges).
  - Outputs go to 0 immediately.
  - A following start sends the full 72 words from address 0.
- Back-to-back transfers: issue start 1 cycle after IDLE, with the RAM contents changed.
  - The second stream reflects the new contents.
